// File: rtl/spi_pkg.sv
// Shared constants, state type and CRC helper for the SPI transmit path.
package spi_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 15;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StShift,
    StTail
  } tx_state_t;

  // CRC-16-CCITT over one word, MSB first, no reflection.
  function automatic logic [WORD_W-1:0] crc16_word(input logic [WORD_W-1:0] crc,
                                                   input logic [WORD_W-1:0] data);
    logic [WORD_W-1:0] c;
    c = crc;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (c[WORD_W-1] ^ data[i]) c = {c[WORD_W-2:0], 1'b0} ^ CRC16_POLY;
      else c = {c[WORD_W-2:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: sclk toggles every CLK_DIV cycles while enabled, idles low.
module spi_sclk_gen
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_50,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  logic [CntW-1:0] cnt_q;
  logic            phase_end;

  // Strobes are high in the cycle before the edge appears on sclk.
  assign phase_end = en && (cnt_q == CntW'(CLK_DIV - 1));
  assign rise      = phase_end && !sclk;
  assign fall      = phase_end && sclk;

  always_ff @(posedge clk_50) begin
    if (reset || !en) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (phase_end) begin
      cnt_q <= '0;
      sclk  <= ~sclk;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/spi_transmit.sv
// SPI mode-0 master transmitter streaming 16-bit words from a buffer, MSB first.
// Define SPI_TX_CRC_EN to append a CRC-16-CCITT word after the payload.
module spi_transmit
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] words_sent
);

  localparam int unsigned TailW = $clog2(CLK_DIV + 1);

  tx_state_t         state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [WORD_W-1:0] hold_q;
  logic [3:0]        bit_cnt_q;
  logic [TailW-1:0]  tail_cnt_q;
  logic [WORD_W-1:0] count_q;
  logic [WORD_W:0]   sent_next;
  logic [WORD_W:0]   total_words;
  logic              rise;
  logic              fall;
  logic              sclk_en;
`ifdef SPI_TX_CRC_EN
  logic [WORD_W-1:0] crc_q;
`endif

  assign mosi      = shreg_q[WORD_W-1];
  assign sclk_en   = (state_q == StShift);
  assign sent_next = {1'b0, words_sent} + (WORD_W + 1)'(1);
`ifdef SPI_TX_CRC_EN
  assign total_words = {1'b0, count_q} + (WORD_W + 1)'(1);
`else
  assign total_words = {1'b0, count_q};
`endif

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk_50(clk_50),
    .reset (reset),
    .en    (sclk_en),
    .sclk  (sclk),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      hold_q     <= '0;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
      count_q    <= '0;
      rd_addr    <= '0;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_sent <= '0;
`ifdef SPI_TX_CRC_EN
      crc_q      <= CRC16_INIT;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            words_sent <= '0;
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              count_q <= word_count;
              rd_addr <= '0;
              cs_n    <= 1'b0;
              busy    <= 1'b1;
              state_q <= StFetch;
            end
          end
        end
        // rd_addr sits at 0 throughout idle, so word 0 is already on rd_data.
        StFetch: begin
          shreg_q   <= rd_data;
          rd_addr   <= rd_addr + ADDR_W'(1);
          bit_cnt_q <= '0;
          state_q   <= StShift;
`ifdef SPI_TX_CRC_EN
          crc_q     <= crc16_word(CRC16_INIT, rd_data);
`endif
        end
        StShift: begin
          // Prefetched word has been stable on rd_data well before the first rise.
          if (rise && bit_cnt_q == 4'd0) hold_q <= rd_data;
          if (fall) begin
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_q  <= '0;
              words_sent <= sent_next[WORD_W-1:0];
              if (sent_next == total_words) begin
                tail_cnt_q <= '0;
                state_q    <= StTail;
              end
`ifdef SPI_TX_CRC_EN
              else if (sent_next == {1'b0, count_q}) begin
                shreg_q <= crc_q;
              end
`endif
              else begin
                shreg_q <= hold_q;
                rd_addr <= rd_addr + ADDR_W'(1);
`ifdef SPI_TX_CRC_EN
                crc_q   <= crc16_word(crc_q, hold_q);
`endif
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              shreg_q   <= {shreg_q[WORD_W-2:0], 1'b0};
            end
          end
        end
        StTail: begin
          if (tail_cnt_q == TailW'(CLK_DIV)) begin
            state_q <= StIdle;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rd_addr <= '0;
          end else begin
            tail_cnt_q <= tail_cnt_q + TailW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
